// File: rtl/disp_scratchpad_bundle_fetcher_pkg.sv
// Shared dispatch scratchpad definitions: register file geometry and the
// bundle fetcher FSM state encoding.
package disp_scratchpad_bundle_fetcher_pkg;

    localparam int unsigned SP_INDEX_W       = 5;
    localparam int unsigned SP_NUM_REGISTERS = 32;
    localparam int unsigned SP_QUEUE_DEPTH   = 32;

    typedef enum logic [2:0] {
        FETCH_IDLE   = 3'd0,
        FETCH_READ   = 3'd1,
        FETCH_OUT    = 3'd2,
        FETCH_STATUS = 3'd3,
        FETCH_POP    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/disp_scratchpad_bundle_fetcher.sv
// Pop-side consumer of the dispatch scratchpad queue. Reads NUM_WORDS
// consecutive registers of the head bundle, hands them downstream as one wide
// word, optionally writes a status word back, then pops the bundle.
module disp_scratchpad_bundle_fetcher
    import disp_scratchpad_bundle_fetcher_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = 8,
    parameter int unsigned FIRST_INDEX  = 0,
    parameter bit          STATUS_EN    = 1'b1,
    parameter int unsigned STATUS_INDEX = 31
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iSPPopBundleValid,
    output logic                    oSPPopBundleReady,
    output logic [31:0]             oSPReadAddress,
    input  logic [31:0]             iSPReadData,
    output logic                    oSPReadValid,
    input  logic                    iSPReadAck,
    output logic [31:0]             oSPWriteAddress,
    output logic [31:0]             oSPWriteData,
    output logic                    oSPWriteValid,
    input  logic                    iSPWriteAck,
    output logic [32*NUM_WORDS-1:0] oBundleData,
    output logic                    oBundleValid,
    input  logic                    iBundleReady,
    input  logic [31:0]             iBundleStatus,
    output logic                    oBusy,
    output logic [31:0]             oBundleCount
);

    if (NUM_WORDS < 1 || FIRST_INDEX + NUM_WORDS > SP_NUM_REGISTERS ||
        STATUS_INDEX >= SP_NUM_REGISTERS) begin : gBadParams
        $error("disp_scratchpad_bundle_fetcher: register window out of range");
    end

    localparam logic [SP_INDEX_W-1:0] LastIdx   = SP_INDEX_W'(NUM_WORDS - 1);
    localparam logic [SP_INDEX_W-1:0] FirstIdx  = SP_INDEX_W'(FIRST_INDEX);
    localparam logic [SP_INDEX_W-1:0] StatusIdx = SP_INDEX_W'(STATUS_INDEX);

    fetch_state_e                   state, stateNext;
    logic [SP_INDEX_W-1:0]          wordIdx;
    logic                           readGap;     // one dead cycle after each read ack
    logic [NUM_WORDS-1:0][31:0]     words;
    logic [31:0]                    statusReg;
    logic [31:0]                    bundleCount;
    logic                           readFire;

    // A read completes only while the request is actually raised; acks during
    // the gap cycle or in any other state are ignored.
    assign readFire = (state == FETCH_READ) && !readGap && iSPReadAck;

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) state <= FETCH_IDLE;
        else        state <= stateNext;
    end

    // Next-state decode and state-driven outputs.
    always_comb begin
        stateNext         = state;
        oSPReadValid      = 1'b0;
        oSPReadAddress    = '0;
        oSPWriteValid     = 1'b0;
        oSPWriteAddress   = '0;
        oSPWriteData      = '0;
        oBundleValid      = 1'b0;
        oSPPopBundleReady = 1'b0;
        unique case (state)
            FETCH_IDLE: begin
                if (iSPPopBundleValid) stateNext = FETCH_READ;
            end
            FETCH_READ: begin
                oSPReadValid   = !readGap;
                oSPReadAddress = 32'(FirstIdx + wordIdx);
                if (readFire && wordIdx == LastIdx) stateNext = FETCH_OUT;
            end
            FETCH_OUT: begin
                oBundleValid = 1'b1;
                if (iBundleReady) stateNext = STATUS_EN ? FETCH_STATUS : FETCH_POP;
            end
            FETCH_STATUS: begin
                oSPWriteValid   = 1'b1;
                oSPWriteAddress = 32'(StatusIdx);
                oSPWriteData    = statusReg;
                if (iSPWriteAck) stateNext = FETCH_POP;
            end
            FETCH_POP: begin
                oSPPopBundleReady = 1'b1;
                stateNext         = FETCH_IDLE;
            end
            default: stateNext = FETCH_IDLE;
        endcase
    end

    // Word capture, read pacing, status latch and pop counter.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            wordIdx     <= '0;
            readGap     <= 1'b0;
            words       <= '0;
            statusReg   <= '0;
            bundleCount <= '0;
        end else begin
            readGap <= 1'b0;
            if (state == FETCH_IDLE) wordIdx <= '0;
            if (readFire) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    if (wordIdx == SP_INDEX_W'(w)) words[w] <= iSPReadData;
                end
                readGap <= 1'b1;
                wordIdx <= (wordIdx == LastIdx) ? '0 : wordIdx + SP_INDEX_W'(1);
            end
            if (state == FETCH_OUT && iBundleReady) statusReg <= iBundleStatus;
            if (state == FETCH_POP) bundleCount <= bundleCount + 32'd1;
        end
    end

    assign oBundleData  = words;
    assign oBusy        = (state != FETCH_IDLE);
    assign oBundleCount = bundleCount;

endmodule

// File: tb/tb_disp_scratchpad_bundle_fetcher.sv
// Bench for the bundle fetcher: a scratchpad queue model with configurable ack
// delay, a downstream sink, and two DUT instances (8-word with status
// write-back, and 1-word without).
module tb_disp_scratchpad_bundle_fetcher;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    always #5 iClock = ~iClock;

    logic        popValid [2];
    logic        popReady [2];
    logic        rdValid  [2];
    logic        rdAck    [2];
    logic        wrValid  [2];
    logic        wrAck    [2];
    logic        bValid   [2];
    logic        busy     [2];
    logic [31:0] rdAddr   [2];
    logic [31:0] rdData   [2];
    logic [31:0] wrAddr   [2];
    logic [31:0] wrData   [2];
    logic [31:0] bCnt     [2];
    logic [255:0] bd0;
    logic [31:0]  bd1;
    logic         bReady = 1'b1;
    logic [31:0]  status = '0;

    // scratchpad model state
    logic [31:0] mem [2][8][32];
    int pushCnt [2] = '{0, 0};
    int popCnt  [2] = '{0, 0};
    int nPops   [2] = '{0, 0};
    int wrCnt   [2] = '{0, 0};
    int rdDly   [2] = '{0, 0};
    int wrDly   [2] = '{0, 0};
    bit rdHeld  [2] = '{0, 0};
    bit wrHeld  [2] = '{0, 0};
    bit prevPop [2] = '{0, 0};
    logic [31:0] prevRdAddr [2];
    logic [31:0] prevWrAddr [2];
    logic [31:0] lastWrAddr [2];
    logic [31:0] lastWrData [2];
    bit randDly = 1'b0;
    int rdLog [$];
    logic [255:0] rx0 [$];

    int nChecks = 0;
    int nFail   = 0;

    assign popValid[0] = (pushCnt[0] != popCnt[0]);
    assign popValid[1] = (pushCnt[1] != popCnt[1]);

    disp_scratchpad_bundle_fetcher #(
        .NUM_WORDS(8), .FIRST_INDEX(0), .STATUS_EN(1'b1), .STATUS_INDEX(31)
    ) dut0 (
        .iClock(iClock), .iReset(iReset),
        .iSPPopBundleValid(popValid[0]), .oSPPopBundleReady(popReady[0]),
        .oSPReadAddress(rdAddr[0]), .iSPReadData(rdData[0]),
        .oSPReadValid(rdValid[0]), .iSPReadAck(rdAck[0]),
        .oSPWriteAddress(wrAddr[0]), .oSPWriteData(wrData[0]),
        .oSPWriteValid(wrValid[0]), .iSPWriteAck(wrAck[0]),
        .oBundleData(bd0), .oBundleValid(bValid[0]), .iBundleReady(bReady),
        .iBundleStatus(status), .oBusy(busy[0]), .oBundleCount(bCnt[0])
    );

    disp_scratchpad_bundle_fetcher #(
        .NUM_WORDS(1), .FIRST_INDEX(4), .STATUS_EN(1'b0), .STATUS_INDEX(31)
    ) dut1 (
        .iClock(iClock), .iReset(iReset),
        .iSPPopBundleValid(popValid[1]), .oSPPopBundleReady(popReady[1]),
        .oSPReadAddress(rdAddr[1]), .iSPReadData(rdData[1]),
        .oSPReadValid(rdValid[1]), .iSPReadAck(rdAck[1]),
        .oSPWriteAddress(wrAddr[1]), .oSPWriteData(wrData[1]),
        .oSPWriteValid(wrValid[1]), .iSPWriteAck(wrAck[1]),
        .oBundleData(bd1), .oBundleValid(bValid[1]), .iBundleReady(bReady),
        .iBundleStatus(status), .oBusy(busy[1]), .oBundleCount(bCnt[1])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] expBundle(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    // Register r of a pushed bundle holds base + r.
    task automatic push(input int u, input logic [31:0] base);
        for (int r = 0; r < 32; r++) mem[u][pushCnt[u] % 8][r] = base + 32'(r);
        pushCnt[u]++;
    endtask

    task automatic waitCount(input int u, input int target, input int budget, input string tag);
        for (int i = 0; i < budget && bCnt[u] != 32'(target); i++) @(negedge iClock);
        check(tag, bCnt[u], 32'(target));
    endtask

    // Scratchpad model and downstream sink, evaluated mid-cycle.
    always @(negedge iClock) begin
        for (int u = 0; u < 2; u++) begin
            rdAck[u] = 1'b0;
            wrAck[u] = 1'b0;
            if (iReset) begin
                popCnt[u] = pushCnt[u];
                rdDly[u]  = 0;
                wrDly[u]  = 0;
                rdHeld[u] = 1'b0;
                wrHeld[u] = 1'b0;
                prevPop[u] = 1'b0;
            end else begin
                if (rdValid[u] || wrValid[u])
                    check("rd_wr_exclusive", rdValid[u] & wrValid[u], 0);
                if (rdHeld[u]) begin
                    check("rd_valid_held", rdValid[u], 1);
                    check("rd_addr_stable", rdAddr[u], prevRdAddr[u]);
                end
                if (rdValid[u]) begin
                    if (rdDly[u] == 0) begin
                        rdAck[u]  = 1'b1;
                        rdData[u] = mem[u][popCnt[u] % 8][rdAddr[u][4:0]];
                        if (u == 0) rdLog.push_back(int'(rdAddr[u]));
                        rdDly[u]  = randDly ? int'($urandom_range(0, 5)) : 0;
                        rdHeld[u] = 1'b0;
                    end else begin
                        rdDly[u]--;
                        rdHeld[u] = 1'b1;
                    end
                    prevRdAddr[u] = rdAddr[u];
                end else rdHeld[u] = 1'b0;
                if (wrHeld[u]) begin
                    check("wr_valid_held", wrValid[u], 1);
                    check("wr_addr_stable", wrAddr[u], prevWrAddr[u]);
                end
                if (wrValid[u]) begin
                    if (wrDly[u] == 0) begin
                        wrAck[u]      = 1'b1;
                        wrCnt[u]++;
                        lastWrAddr[u] = wrAddr[u];
                        lastWrData[u] = wrData[u];
                        wrDly[u]      = randDly ? int'($urandom_range(0, 5)) : 0;
                        wrHeld[u]     = 1'b0;
                    end else begin
                        wrDly[u]--;
                        wrHeld[u] = 1'b1;
                    end
                    prevWrAddr[u] = wrAddr[u];
                end else wrHeld[u] = 1'b0;
                if (popReady[u]) begin
                    check("pop_single_cycle", prevPop[u], 0);
                    check("pop_nonempty", pushCnt[u] != popCnt[u], 1);
                    popCnt[u]++;
                    nPops[u]++;
                end
                prevPop[u] = popReady[u];
                if (u == 0 && bValid[0] && bReady) rx0.push_back(bd0);
            end
        end
    end

    initial begin
        logic [255:0] snap;
        bit ok;
        int n;

        // reset state
        repeat (3) @(negedge iClock);
        check("rst_busy", busy[0], 0);
        check("rst_rd_valid", rdValid[0], 0);
        check("rst_wr_valid", wrValid[0], 0);
        check("rst_pop", popReady[0], 0);
        check("rst_bvalid", bValid[0], 0);
        check("rst_count", bCnt[0], 0);
        check("rst_data", bd0, 0);
        check("rst_wr_data", wrData[0], 0);
        check("rst_dut1_busy", busy[1], 0);
        iReset = 1'b0;
        @(negedge iClock);

        // 1: single bundle, regs A0..
        status = 32'h5000_0001;
        push(0, 32'hA0);
        waitCount(0, 1, 200, "t1_count");
        check("t1_rx_n", 256'(rx0.size()), 1);
        check("t1_data", rx0[0],
              256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
        check("t1_reads_n", 256'(rdLog.size()), 8);
        for (int i = 0; i < 8; i++) check("t1_read_addr", 256'(rdLog[i]), 256'(i));
        check("t1_wr_n", 256'(wrCnt[0]), 1);
        check("t1_wr_addr", lastWrAddr[0], 31);
        check("t1_wr_data", lastWrData[0], 32'h5000_0001);
        check("t1_pops", 256'(nPops[0]), 1);
        @(negedge iClock);
        check("t1_idle", busy[0], 0);

        // 2: three bundles back-to-back
        rx0.delete();
        push(0, 32'h100); push(0, 32'h200); push(0, 32'h300);
        check("t2_q_full", 256'(pushCnt[0] - popCnt[0]), 3);
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (!popReady[0] && n < 200) begin @(negedge iClock); n++; end
            check("t2_pop_seen", popReady[0], 1);
            @(negedge iClock);
            if (b < 2) begin
                @(negedge iClock);
                check("t2_b2b_read", rdValid[0], 1);
            end
        end
        waitCount(0, 4, 50, "t2_count");
        check("t2_rx_n", 256'(rx0.size()), 3);
        check("t2_data0", rx0[0], expBundle(32'h100));
        check("t2_data1", rx0[1], expBundle(32'h200));
        check("t2_data2", rx0[2], expBundle(32'h300));
        check("t2_q_empty", 256'(pushCnt[0] - popCnt[0]), 0);
        check("t2_pops", 256'(nPops[0]), 4);

        // 3: downstream stall in OUT
        bReady = 1'b0;
        status = 32'h33;
        push(0, 32'h400);
        n = 0;
        while (!bValid[0] && n < 100) begin @(negedge iClock); n++; end
        check("t3_valid", bValid[0], 1);
        snap = bd0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge iClock);
            if (!bValid[0] || bd0 !== snap || wrValid[0] || popReady[0]) ok = 1'b0;
        end
        check("t3_hold", ok, 1);
        check("t3_data", snap, expBundle(32'h400));
        check("t3_no_write", 256'(wrCnt[0]), 4);
        check("t3_no_pop", 256'(nPops[0]), 4);
        bReady = 1'b1;
        waitCount(0, 5, 50, "t3_count");
        check("t3_wr_data", lastWrData[0], 32'h33);

        // 4: random ack delays
        rx0.delete();
        randDly = 1'b1;
        push(0, 32'h500); push(0, 32'h600);
        waitCount(0, 7, 600, "t4_count");
        randDly = 1'b0;
        check("t4_data0", rx0[0], expBundle(32'h500));
        check("t4_data1", rx0[1], expBundle(32'h600));
        check("t4_writes", 256'(wrCnt[0]), 7);
        @(negedge iClock);

        // 5: one word, no status write-back
        status = 32'hDEAD;
        push(1, 32'h40);
        n = 0;
        while (!bValid[1] && n < 100) begin @(negedge iClock); n++; end
        check("t5_valid", bValid[1], 1);
        check("t5_data", bd1, 32'h44);
        @(negedge iClock);
        check("t5_pop_next", popReady[1], 1);
        check("t5_no_wr_valid", wrValid[1], 0);
        waitCount(1, 1, 20, "t5_count");
        check("t5_no_write", 256'(wrCnt[1]), 0);
        check("t5_reg31", mem[1][0][31], 32'h5F);

        // 6: reset in the middle of the read phase
        rdLog.delete();
        rx0.delete();
        push(0, 32'hC0);
        n = 0;
        while (!(rdValid[0] && rdAddr[0] == 32'd3) && n < 100) begin @(negedge iClock); n++; end
        check("t6_reach_k3", rdAddr[0], 3);
        iReset = 1'b1;
        @(negedge iClock);
        check("t6_busy", busy[0], 0);
        check("t6_rd_valid", rdValid[0], 0);
        check("t6_pop", popReady[0], 0);
        check("t6_count", bCnt[0], 0);
        check("t6_data", bd0, 0);
        check("t6_no_pop", 256'(nPops[0]), 7);
        @(negedge iClock);
        iReset = 1'b0;
        @(negedge iClock);
        rdLog.delete();
        push(0, 32'hC0);
        waitCount(0, 1, 200, "t6_count_after");
        check("t6_first_addr", 256'(rdLog[0]), 0);
        check("t6_refetch", rx0[rx0.size() - 1], expBundle(32'hC0));
        check("t6_pops", 256'(nPops[0]), 8);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
